swap_network: RTL and testbench
===============================

# swap_network

Parametrised, registered lane-permutation unit, successor to the two-word combinational swap. It accepts a vector of LANES words of WIDTH bits over a valid/ready handshake and applies one of four per-transaction permutations: pass, pairwise swap, rotate, or reverse. The result is presented from a single output register stage at full throughput. It sits between the register-file read ports and the ALU/writeback datapath of the 20-bit core, and also carries a wrapping transaction counter for debug.

## Interface
Parameters:
- WIDTH, 20, bits per lane (≥1)
- LANES, 4, number of lanes (power of two, ≥2)
- CNT_W, 16, width of the transaction counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- in_valid  input  1  input word vector valid
- in_ready  output  1  unit can accept this cycle
- in_data  input  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- in_mode  input  2  0 PASS, 1 PAIR_SWAP, 2 ROTATE, 3 REVERSE
- in_amt  input  clog2(LANES)  rotate amount; used only in ROTATE
- out_valid  output  1  output register holds a result
- out_ready  input  1  consumer accepts this cycle
- out_data  output  LANES*WIDTH  permuted result, same lane packing
- xfer_count  output  CNT_W  number of completed output handshakes, wrapping

## Operation
- Input handshake fires when in_valid && in_ready. Output handshake fires when out_valid && out_ready.
- in_ready = rst_n && (!out_valid || out_ready). This is combinational; there is no combinational path from in_valid to in_ready.
- Permutation, out lane j:
  - PASS: in lane j.
  - PAIR_SWAP: in lane j^1, i.e. lanes 2k and 2k+1 exchange.
  - ROTATE: in lane (j + in_amt) mod LANES. Wrap-around is inherent because in_amt is clog2(LANES) bits.
  - REVERSE: in lane LANES-1-j.
- in_mode and in_amt are sampled only on an input handshake. in_amt is ignored in modes other than ROTATE.
- Register update on the rising edge:
  - Input handshake: out_data ← perm(in_data) and out_valid ← 1.
  - Output handshake without an input handshake: out_valid ← 0 and out_data holds.
  - Simultaneous input and output handshake: the new result replaces the old one, out_valid stays 1, and throughput is 1 vector/cycle.
  - Neither: hold. out_data is stable while out_valid && !out_ready.
- xfer_count increments by 1 on every output handshake and wraps from 2^CNT_W-1 to 0.
- No data-dependent behaviour. All widths are exact; there is no arithmetic on data.

## Timing
- Latency is 1 cycle: an input accepted at edge N is visible on out_data/out_valid after edge N.
- Reset (rst_n low, asynchronous assert): out_valid=0, out_data=0, xfer_count=0, and in_ready=0 immediately.
- First edge after rst_n rises: in_ready=1. Deassertion of rst_n is synchronised externally.
- Reset mid-transaction: a held output is discarded and is not counted in xfer_count.
- Backpressure: with out_ready low, at most one vector is held and in_ready=0. in_ready returns to 1 in the same cycle out_ready rises.
- The design has no state machine beyond the out_valid bit and the counter.

## Structure
- Shared package swap_pkg holds:
  - the mode enum (MODE_PASS=0, MODE_PAIR_SWAP=1, MODE_ROTATE=2, MODE_REVERSE=3);
  - the default WIDTH=20 constant used core-wide.
- Sub-module swap_perm: purely combinational, parameters WIDTH/LANES, inputs data/mode/amt, output permuted data. swap_network instantiates it ahead of the output register.
- Permutation logic sits in swap_perm; the handshake, register, and counter sit in swap_network.

## Test plan
Defaults WIDTH=20, LANES=4. in_data lanes 0..3 = 0x00001, 0x00002, 0x00003, 0x00004.
- Reset: rst_n low mid-stream → out_valid=0, out_data=0, xfer_count=0, and in_ready=0 without waiting for a clock edge.
- Modes, one vector each with out_ready=1:
  - PASS → 1,2,3,4.
  - PAIR_SWAP → 2,1,4,3.
  - REVERSE → 4,3,2,1.
  - Each result appears 1 cycle after acceptance.
- ROTATE amt=0..3:
  - amt=1 → 2,3,4,1.
  - amt=3 → 4,1,2,3.
  - amt=0 → unchanged.
- Backpressure: out_ready=0 for 5 cycles with in_valid held.
  - Required: in_ready=0, out_data stable, xfer_count unchanged.
  - Then out_ready=1: exactly one handshake per cycle, no vector lost or duplicated.
- Streaming: 100 random vectors and modes with random out_ready, checked against a reference model.
  - Required: order preserved, xfer_count=100 at the end.
  - With CNT_W=4: count wraps to 100 mod 16 = 4.

Source files
------------

// File: rtl/swap_pkg.sv
// swap_pkg: shared definitions for the lane-permutation unit.
//   swap_mode_e - per-transaction permutation select carried on in_mode
//   CORE_WIDTH  - datapath word width used across the 20-bit core
package swap_pkg;

  typedef enum logic [1:0] {
    MODE_PASS      = 2'd0,
    MODE_PAIR_SWAP = 2'd1,
    MODE_ROTATE    = 2'd2,
    MODE_REVERSE   = 2'd3
  } swap_mode_e;

  localparam int unsigned CORE_WIDTH = 20;

endpackage

// File: rtl/swap_perm.sv
// swap_perm: purely combinational lane permutation.
// Ports:
//   data      - LANES words of WIDTH bits, lane i at [i*WIDTH +: WIDTH]
//   mode      - swap_mode_e encoding (pass / pair swap / rotate / reverse)
//   amt       - rotate amount, only meaningful in MODE_ROTATE
//   perm_data - permuted words, same lane packing as data
module swap_perm
  import swap_pkg::*;
#(
  parameter int unsigned WIDTH = CORE_WIDTH,
  parameter int unsigned LANES = 4,
  parameter int unsigned AMT_W = $clog2(LANES)
) (
  input  logic [LANES*WIDTH-1:0] data,
  input  logic [1:0]             mode,
  input  logic [AMT_W-1:0]       amt,
  output logic [LANES*WIDTH-1:0] perm_data
);

  logic [WIDTH-1:0] lane_in [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_unpack
    assign lane_in[i] = data[i*WIDTH +: WIDTH];
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    localparam logic [AMT_W-1:0] J = AMT_W'(j);
    logic [AMT_W-1:0] src;

    // Source lane indices are AMT_W bits wide and LANES is a power of two,
    // so rotate wraps for free and ~J equals LANES-1-j.
    always_comb begin
      src = J;
      case (mode)
        MODE_PASS:      src = J;
        MODE_PAIR_SWAP: src = J ^ AMT_W'(1);
        MODE_ROTATE:    src = J + amt;
        MODE_REVERSE:   src = ~J;
        default:        src = J;
      endcase
    end

    assign perm_data[j*WIDTH +: WIDTH] = lane_in[src];
  end

endmodule

// File: rtl/swap_network.sv
// swap_network: registered lane-permutation unit with valid/ready handshake.
// Ports:
//   clk, rst_n            - rising-edge clock, async active-low reset
//   in_valid/in_ready     - input handshake; in_ready is combinational
//   in_data/in_mode/in_amt - word vector and permutation, sampled on accept
//   out_valid/out_ready   - output handshake from a single register stage
//   out_data              - permuted vector, held while stalled
//   xfer_count            - wrapping count of completed output handshakes
module swap_network
  import swap_pkg::*;
#(
  parameter int unsigned WIDTH = CORE_WIDTH,
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*WIDTH-1:0]     in_data,
  input  logic [1:0]                 in_mode,
  input  logic [$clog2(LANES)-1:0]   in_amt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*WIDTH-1:0]     out_data,
  output logic [CNT_W-1:0]           xfer_count
);

  logic                   in_fire;
  logic                   out_fire;
  logic [LANES*WIDTH-1:0] perm_data;

  swap_perm #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_perm (
    .data      (in_data),
    .mode      (in_mode),
    .amt       (in_amt),
    .perm_data (perm_data)
  );

  // rst_n gates in_ready so nothing is offered acceptance while in reset.
  assign in_ready = rst_n && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= perm_data;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (out_fire) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_swap_network.sv
module tb_swap_network;

  localparam int W = 20;
  localparam int L = 4;
  localparam int DW = W * L;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    in_mode = 2'd0;
  logic [1:0]    in_amt = 2'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [15:0]   xfer_count;

  logic          in_ready_w;
  logic          out_valid_w;
  logic [DW-1:0] out_data_w;
  logic [3:0]    xfer_count_w;

  swap_network #(.WIDTH(W), .LANES(L), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_count(xfer_count)
  );

  swap_network #(.WIDTH(W), .LANES(L), .CNT_W(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_data), .in_mode(in_mode), .in_amt(in_amt),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .xfer_count(xfer_count_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;
  int rdy_mode = 0;      // 0: always ready, 1: stalled, 2: random
  bit drv_busy = 0;
  logic [DW-1:0] sb_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pk(input logic [W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [DW-1:0] perm_model(input logic [DW-1:0] d, input logic [1:0] m,
                                              input logic [1:0] a);
    logic [DW-1:0] r;
    int src;
    r = '0;
    for (int j = 0; j < L; j++) begin
      case (m)
        2'd0:    src = j;
        2'd1:    src = j ^ 1;
        2'd2:    src = (j + int'(a)) % L;
        default: src = L - 1 - j;
      endcase
      r[j*W +: W] = d[src*W +: W];
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input logic [1:0] a,
                      input logic [DW-1:0] exp);
    bit acc;
    acc = 0;
    drv_busy = 1;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_amt   = a;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(exp);
        acc = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout actual=not_accepted required=accepted t=%0t", $time);
    end else begin
      chk("latency_valid", DW'(out_valid), DW'(1));
      chk("latency_data", out_data, exp);
    end
    drv_busy = 0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0 && !drv_busy && !out_valid) done = 1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout actual=pending%0d required=pending0", sb_q.size());
    end
  endtask

  // Sink: out_ready changes 2 time units after the edge.
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every output handshake pops the scoreboard in order.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected actual=%h required=no_output", out_data);
      end else begin
        chk("sb_data", out_data, sb_q.pop_front());
      end
      chk("count_track", DW'(xfer_count), DW'(exp_count[15:0]));
      exp_count++;
    end
  end

  logic [DW-1:0] base;
  logic [DW-1:0] a_exp;
  logic [15:0]   snap;

  initial begin
    base = pk(20'h00001, 20'h00002, 20'h00003, 20'h00004);

    #3;
    chk("rst_in_ready", DW'(in_ready), DW'(0));
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_count", DW'(xfer_count), DW'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", DW'(in_ready), DW'(1));

    send(base, 2'd0, 2'd2, pk(20'h1, 20'h2, 20'h3, 20'h4));
    send(base, 2'd1, 2'd3, pk(20'h2, 20'h1, 20'h4, 20'h3));
    send(base, 2'd3, 2'd1, pk(20'h4, 20'h3, 20'h2, 20'h1));
    send(base, 2'd2, 2'd0, pk(20'h1, 20'h2, 20'h3, 20'h4));
    send(base, 2'd2, 2'd1, pk(20'h2, 20'h3, 20'h4, 20'h1));
    send(base, 2'd2, 2'd2, pk(20'h3, 20'h4, 20'h1, 20'h2));
    send(base, 2'd2, 2'd3, pk(20'h4, 20'h1, 20'h2, 20'h3));
    drain();
    chk("count_directed", DW'(xfer_count), DW'(7));

    // Backpressure: hold one result, keep a second vector waiting.
    rdy_mode = 1;
    a_exp = pk(20'h4, 20'h3, 20'h2, 20'h1);
    send(base, 2'd3, 2'd0, a_exp);
    snap = xfer_count;
    fork
      send(pk(20'hAAAAA, 20'h55555, 20'h12345, 20'hFEDCB), 2'd1, 2'd0,
           pk(20'h55555, 20'hAAAAA, 20'hFEDCB, 20'h12345));
    join_none
    #0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", DW'(in_ready), DW'(0));
      chk("bp_out_data", out_data, a_exp);
      chk("bp_count", DW'(xfer_count), DW'(snap));
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    drain();
    chk("bp_count_after", DW'(xfer_count), DW'(snap + 16'd2));

    // Reset while a result is held: it is discarded, not counted.
    rdy_mode = 1;
    send(pk(20'h00F00, 20'h0A0A0, 20'h11111, 20'h22222), 2'd0, 2'd0,
         pk(20'h00F00, 20'h0A0A0, 20'h11111, 20'h22222));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", DW'(in_ready), DW'(0));
    chk("midrst_out_valid", DW'(out_valid), DW'(0));
    chk("midrst_out_data", out_data, '0);
    chk("midrst_count", DW'(xfer_count), DW'(0));
    chk("midrst_count_wrap", DW'(xfer_count_w), DW'(0));
    sb_q.delete();
    exp_count = 0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready_back", DW'(in_ready), DW'(1));

    // Streaming with random data, modes and backpressure.
    rdy_mode = 2;
    for (int n = 0; n < 100; n++) begin
      logic [DW-1:0] d;
      logic [1:0] m, a;
      d = DW'({$urandom, $urandom, $urandom});
      m = 2'($urandom_range(0, 3));
      a = 2'($urandom_range(0, 3));
      send(d, m, a, perm_model(d, m, a));
    end
    rdy_mode = 0;
    drain();
    chk("stream_count", DW'(xfer_count), DW'(100));
    chk("stream_count_wrap", DW'(xfer_count_w), DW'(4));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
